// File: rtl/gpio_input_capture.sv
// GPIO input capture: sync + debounce per pin, edge detect into W1C pending flags, level irq.
// Optional edge event counter at 0x14 when GPIO_CAPTURE_COUNTER_EN is defined.
module gpio_input_capture #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             wr_en,
  input  logic [4:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic [WIDTH-1:0] InPort,
  output logic             irq
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] DcntMax = CntW'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] AddrIdr  = 3'd0;
  localparam logic [2:0] AddrRise = 3'd1;
  localparam logic [2:0] AddrFall = 3'd2;
  localparam logic [2:0] AddrPend = 3'd3;
  localparam logic [2:0] AddrIer  = 3'd4;
  localparam logic [2:0] AddrCnt  = 3'd5;

  logic [WIDTH-1:0]           s1Q, s2Q, dbQ, dbD;
  logic [WIDTH-1:0][CntW-1:0] dcntQ, dcntD;
  logic [WIDTH-1:0]           riseEnQ, fallEnQ, pendQ, ierQ;
  logic [WIDTH-1:0]           setMask, pendW1c;
  logic [31:0]                cntRd;
  logic [2:0]                 regSel;
  logic                       wrStrobe, rdStrobe;
  logic                       unusedBits;

  assign regSel     = addr[4:2];
  assign wrStrobe   = ce & wr_en;
  assign rdStrobe   = ce & ~wr_en;
  assign pendW1c    = (wrStrobe && regSel == AddrPend) ? wdata[WIDTH-1:0] : '0;
  assign unusedBits = ^{addr[1:0], wdata};

  // A pin flips only after s2 disagrees with db for DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    dbD     = dbQ;
    dcntD   = '0;
    setMask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s2Q[i] != dbQ[i]) begin
        if (dcntQ[i] == DcntMax) begin
          dbD[i]     = s2Q[i];
          setMask[i] = s2Q[i] ? riseEnQ[i] : fallEnQ[i];
        end else begin
          dcntD[i] = dcntQ[i] + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1Q     <= '0;
      s2Q     <= '0;
      dbQ     <= '0;
      dcntQ   <= '0;
      riseEnQ <= '0;
      fallEnQ <= '0;
      pendQ   <= '0;
      ierQ    <= '0;
    end else begin
      s1Q   <= InPort;
      s2Q   <= s1Q;
      dbQ   <= dbD;
      dcntQ <= dcntD;
      // Set wins over a same-cycle W1C.
      pendQ <= (pendQ & ~pendW1c) | setMask;
      if (wrStrobe && regSel == AddrRise) riseEnQ <= wdata[WIDTH-1:0];
      if (wrStrobe && regSel == AddrFall) fallEnQ <= wdata[WIDTH-1:0];
      if (wrStrobe && regSel == AddrIer)  ierQ    <= wdata[WIDTH-1:0];
    end
  end

`ifdef GPIO_CAPTURE_COUNTER_EN
  logic [15:0] cntQ;

  // Counts cycles with at least one new pending edge; a write clears and beats the increment.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cntQ <= '0;
    end else if (wrStrobe && regSel == AddrCnt) begin
      cntQ <= '0;
    end else if (|setMask && cntQ != 16'hFFFF) begin
      cntQ <= cntQ + 16'd1;
    end
  end

  assign cntRd = 32'(cntQ);
`else
  assign cntRd = '0;
`endif

  always_comb begin
    rdata = '0;
    if (rdStrobe) begin
      case (regSel)
        AddrIdr:  rdata = 32'(dbQ);
        AddrRise: rdata = 32'(riseEnQ);
        AddrFall: rdata = 32'(fallEnQ);
        AddrPend: rdata = 32'(pendQ);
        AddrIer:  rdata = 32'(ierQ);
        AddrCnt:  rdata = cntRd;
        default:  rdata = '0;
      endcase
    end
  end

  assign irq = |(pendQ & ierQ);

endmodule

// File: tb/tb_gpio_input_capture.sv
// Self-checking bench for gpio_input_capture: directed scenarios plus randomized traffic
// against a sliding-window reference model of sync, debounce, pending flags and counter.
module tb_gpio_input_capture;

  localparam int W  = 4;
  localparam int DC = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ce = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [W-1:0] InPort = '0;
  logic        irq;

  int nChecks = 0;
  int nErrors = 0;

  gpio_input_capture #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
    .clk    (clk),
    .reset  (reset),
    .ce     (ce),
    .wr_en  (wr_en),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .InPort (InPort),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  // Reference model: pins reach the debouncer two edges late; a pin flips once the last DC
  // samples seen by the debouncer all differ from its current value.
  logic [W-1:0] dly[$];
  logic [W-1:0] seenHist[$];
  logic [W-1:0] mDb, mRise, mFall, mPend, mIer;
  logic [15:0]  mCnt;

  task automatic modelEdge();
    logic [W-1:0] seen, setM, w1c;
    logic flip;
    if (!reset) begin
      dly.delete(); dly.push_back('0); dly.push_back('0);
      seenHist.delete();
      mDb = '0; mRise = '0; mFall = '0; mPend = '0; mIer = '0; mCnt = '0;
      return;
    end
    seen = dly.pop_front();
    dly.push_back(InPort);
    seenHist.push_back(seen);
    if (seenHist.size() > DC) void'(seenHist.pop_front());
    setM = '0;
    if (seenHist.size() == DC) begin
      for (int i = 0; i < W; i++) begin
        flip = 1'b1;
        for (int j = 0; j < DC; j++) if (seenHist[j][i] == mDb[i]) flip = 1'b0;
        if (flip) begin
          mDb[i]  = ~mDb[i];
          setM[i] = mDb[i] ? mRise[i] : mFall[i];
        end
      end
    end
    w1c = '0;
    if (ce && wr_en) begin
      case (addr[4:2])
        3'd1: mRise = wdata[W-1:0];
        3'd2: mFall = wdata[W-1:0];
        3'd3: w1c   = wdata[W-1:0];
        3'd4: mIer  = wdata[W-1:0];
        default: ;
      endcase
    end
    mPend = (mPend & ~w1c) | setM;
`ifdef GPIO_CAPTURE_COUNTER_EN
    if (ce && wr_en && addr[4:2] == 3'd5) mCnt = '0;
    else if (setM != '0 && mCnt != 16'hFFFF) mCnt = mCnt + 16'd1;
`endif
  endtask

  function automatic logic [31:0] mRead(input logic [4:0] a);
    case (a[4:2])
      3'd0: return 32'(mDb);
      3'd1: return 32'(mRise);
      3'd2: return 32'(mFall);
      3'd3: return 32'(mPend);
      3'd4: return 32'(mIer);
      3'd5: return 32'(mCnt);
      default: return 32'd0;
    endcase
  endfunction

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      modelEdge();
      #1;
    end
  endtask

  task automatic busWrite(input logic [4:0] a, input logic [31:0] d);
    ce = 1'b1; wr_en = 1'b1; addr = a; wdata = d;
    tick();
    ce = 1'b0; wr_en = 1'b0;
  endtask

  task automatic busRead(input logic [4:0] a, output logic [31:0] d);
    ce = 1'b1; wr_en = 1'b0; addr = a;
    #1;
    d = rdata;
    ce = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b0; InPort = '0;
    tick(3);
    reset = 1'b1;
    nChecks++;
    if (rdata !== 32'd0) begin
      nErrors++; $display("FAIL reset_idle_rdata got %h exp 0", rdata);
    end
    for (int a = 0; a < 6; a++) begin
      busRead(5'(a * 4), d);
      nChecks++;
      if (d !== 32'd0) begin
        nErrors++; $display("FAIL reset_reg%0d got %h exp 0", a, d);
      end
    end
    nChecks++;
    if (irq !== 1'b0) begin
      nErrors++; $display("FAIL reset_irq got %b exp 0", irq);
    end
  endtask

  task automatic test_rise();
    logic [31:0] d;
    busWrite(5'h04, 32'hF);
    busWrite(5'h10, 32'h1);
    InPort = 4'b0001;
    tick(5);
    busRead(5'h00, d);
    nChecks++;
    if (d !== 32'h0) begin
      nErrors++; $display("FAIL rise_early_idr got %h exp 0", d);
    end
    tick();
    busRead(5'h00, d);
    nChecks++;
    if (d !== 32'h1) begin
      nErrors++; $display("FAIL rise_idr got %h exp 1", d);
    end
    busRead(5'h0C, d);
    nChecks++;
    if (d !== 32'h1) begin
      nErrors++; $display("FAIL rise_pend got %h exp 1", d);
    end
    nChecks++;
    if (irq !== 1'b1) begin
      nErrors++; $display("FAIL rise_irq got %b exp 1", irq);
    end
    busWrite(5'h0C, 32'h1);
    busRead(5'h0C, d);
    nChecks++;
    if (d !== 32'h0 || irq !== 1'b0) begin
      nErrors++; $display("FAIL rise_w1c got pend %h irq %b exp 0 0", d, irq);
    end
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    InPort = 4'b0000;
    tick(10);
    InPort = 4'b0100;
    tick(3);
    InPort = 4'b0000;
    tick(10);
    busRead(5'h00, d);
    nChecks++;
    if (d !== 32'h0) begin
      nErrors++; $display("FAIL glitch_idr got %h exp 0", d);
    end
    busRead(5'h0C, d);
    nChecks++;
    if (d !== 32'h0) begin
      nErrors++; $display("FAIL glitch_pend got %h exp 0", d);
    end
    InPort = 4'b0100;
    tick(10);
    busRead(5'h00, d);
    nChecks++;
    if (d !== 32'h4) begin
      nErrors++; $display("FAIL glitch_long_idr got %h exp 4", d);
    end
    busWrite(5'h0C, 32'hF);
    InPort = 4'b0000;
    tick(10);
  endtask

  task automatic test_fall();
    logic [31:0] d;
    busWrite(5'h04, 32'h0);
    busWrite(5'h08, 32'h8);
    busWrite(5'h10, 32'hF);
    busWrite(5'h0C, 32'hF);
    InPort = 4'b1000;
    tick(10);
    busRead(5'h0C, d);
    nChecks++;
    if (d !== 32'h0 || irq !== 1'b0) begin
      nErrors++; $display("FAIL fall_on_rise got pend %h irq %b exp 0 0", d, irq);
    end
    InPort = 4'b0000;
    tick(10);
    busRead(5'h0C, d);
    nChecks++;
    if (d !== 32'h8 || irq !== 1'b1) begin
      nErrors++; $display("FAIL fall_pend got pend %h irq %b exp 8 1", d, irq);
    end
    busWrite(5'h0C, 32'hF);
  endtask

  task automatic test_set_w1c();
    logic [31:0] d;
    busWrite(5'h08, 32'h0);
    busWrite(5'h04, 32'h1);
    busWrite(5'h10, 32'h1);
    InPort = 4'b0001;
    tick(5);
    busWrite(5'h0C, 32'h1);
    busRead(5'h0C, d);
    nChecks++;
    if (d !== 32'h1 || irq !== 1'b1) begin
      nErrors++; $display("FAIL set_vs_w1c got pend %h irq %b exp 1 1", d, irq);
    end
    busWrite(5'h0C, 32'h1);
    InPort = 4'b0000;
    tick(10);
  endtask

  task automatic test_counter();
    logic [31:0] d;
`ifdef GPIO_CAPTURE_COUNTER_EN
    busWrite(5'h04, 32'hF);
    busWrite(5'h14, 32'h0);
    InPort = 4'hF;
    tick();
    InPort = 4'h0;
    tick(10);
    busRead(5'h14, d);
    nChecks++;
    if (d !== 32'd0) begin
      nErrors++; $display("FAIL cnt_one_cycle_pulse got %h exp 0", d);
    end
    InPort = 4'hF;
    tick(10);
    busRead(5'h14, d);
    nChecks++;
    if (d !== 32'd1) begin
      nErrors++; $display("FAIL cnt_first got %h exp 1", d);
    end
    for (int k = 0; k < 3; k++) begin
      InPort = 4'h0; tick(10);
      InPort = 4'(1 << k); tick(10);
    end
    busRead(5'h14, d);
    nChecks++;
    if (d !== 32'd4) begin
      nErrors++; $display("FAIL cnt_four got %h exp 4", d);
    end
    busWrite(5'h14, 32'h1234);
    busRead(5'h14, d);
    nChecks++;
    if (d !== 32'd0) begin
      nErrors++; $display("FAIL cnt_clear got %h exp 0", d);
    end
    InPort = 4'h0;
    tick(10);
`else
    busWrite(5'h14, 32'hFFFF);
    busRead(5'h14, d);
    nChecks++;
    if (d !== 32'd0) begin
      nErrors++; $display("FAIL cnt_absent got %h exp 0", d);
    end
`endif
    busWrite(5'h0C, 32'hF);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    busWrite(5'h04, 32'h3);
    busWrite(5'h08, 32'h0);
    busWrite(5'h10, 32'h3);
    InPort = 4'b0011;
    tick(10);
    busRead(5'h0C, d);
    nChecks++;
    if (d !== 32'h3 || irq !== 1'b1) begin
      nErrors++; $display("FAIL rmid_setup got pend %h irq %b exp 3 1", d, irq);
    end
    InPort = 4'b0000;
    tick(3);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int a = 0; a < 5; a++) begin
      busRead(5'(a * 4), d);
      nChecks++;
      if (d !== 32'h0) begin
        nErrors++; $display("FAIL rmid_reg%0d got %h exp 0", a, d);
      end
    end
    nChecks++;
    if (irq !== 1'b0) begin
      nErrors++; $display("FAIL rmid_irq got %b exp 0", irq);
    end
    tick(10);
    busRead(5'h00, d);
    nChecks++;
    if (d !== 32'h0) begin
      nErrors++; $display("FAIL rmid_after got %h exp 0", d);
    end
  endtask

  task automatic test_reset_release();
    logic [31:0] d;
    InPort = 4'hF;
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(DC + 1);
    busRead(5'h00, d);
    nChecks++;
    if (d !== 32'h0) begin
      nErrors++; $display("FAIL rel_early_idr got %h exp 0", d);
    end
    tick();
    busRead(5'h00, d);
    nChecks++;
    if (d !== 32'hF) begin
      nErrors++; $display("FAIL rel_idr got %h exp f", d);
    end
    busRead(5'h0C, d);
    nChecks++;
    if (d !== 32'h0) begin
      nErrors++; $display("FAIL rel_pend got %h exp 0", d);
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [4:0]  a;
    int holdLeft = 0;
    for (int c = 0; c < 2000; c++) begin
      if (holdLeft == 0) begin
        InPort = 4'($urandom);
        holdLeft = $urandom_range(1, 7);
      end
      holdLeft--;
      if ($urandom_range(0, 7) == 0) busWrite(5'($urandom), $urandom);
      else tick();
      nChecks++;
      if (irq !== |(mPend & mIer)) begin
        nErrors++; $display("FAIL rand_irq cyc %0d got %b exp %b", c, irq, |(mPend & mIer));
      end
      a = 5'($urandom);
      busRead(a, d);
      nChecks++;
      if (d !== mRead(a)) begin
        nErrors++; $display("FAIL rand_read cyc %0d addr %h got %h exp %h", c, a, d, mRead(a));
      end
    end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_glitch();
    test_fall();
    test_set_w1c();
    test_counter();
    test_reset_mid();
    test_reset_release();
    test_random();
    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
